// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the LC-3 memory access controller.
// State encoding, default I/O address and SRAM address width.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    IO     = 2'd2,
    DONE   = 2'd3
  } mac_state_t;

  localparam logic [15:0] DEF_IO_ADDR = 16'hFFFF;
  localparam int          SRAM_AW     = 20;
  localparam int          CNT_W       = 3;

endpackage

// File: rtl/mem_io_regs.sv
// Memory-mapped I/O: two-flop Switches synchronizer and the hex-display register.
// Sync latency two edges; Hex_out loads one edge after hex_we; no backpressure.
module mem_io_regs (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Switches,
  output logic [15:0] sw_sync,
  input  logic        hex_we,
  input  logic [15:0] hex_wdata,
  output logic [15:0] Hex_out
);

  logic [15:0] sw_meta;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      Hex_out <= '0;
    end else begin
      sw_meta <= Switches;
      sw_sync <= sw_meta;
      if (hex_we) Hex_out <= hex_wdata;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns single-cycle LC-3 read/write requests into timed async-SRAM strobes or I/O accesses.
// SRAM completes WAIT_CYCLES+1 cycles after Req, I/O after 2; Req outside IDLE is dropped.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = DEF_IO_ADDR
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Req,
  input  logic               Write,
  input  logic [15:0]        Addr,
  input  logic [15:0]        Wdata,
  output logic [15:0]        Rdata,
  output logic               Ready,
  output logic               Busy,
  input  logic [15:0]        Switches,
  output logic [15:0]        Hex_out,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DOUT,
  input  logic [15:0]        SRAM_DIN,
  output logic               SRAM_DOE,
  output logic               CE_N,
  output logic               OE_N,
  output logic               WE_N,
  output logic               UB_N,
  output logic               LB_N
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 7) begin : g_bad_wait
    $error("mem_access_ctrl: WAIT_CYCLES must be within 1..7");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  mac_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             write_l;
  logic [15:0]      wdata_l;
  logic [15:0]      sram_addr_l;
  logic [15:0]      sw_sync;
  logic             hex_we;

  assign SRAM_ADDR = {4'b0, sram_addr_l};
  assign SRAM_DOUT = wdata_l;
  assign hex_we    = (state == IO) && write_l;

  mem_io_regs u_io_regs (
    .Clk       (Clk),
    .Reset     (Reset),
    .Switches  (Switches),
    .sw_sync   (sw_sync),
    .hex_we    (hex_we),
    .hex_wdata (wdata_l),
    .Hex_out   (Hex_out)
  );

  // Every strobe is registered and set on the transition into the state that owns it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      write_l     <= 1'b0;
      wdata_l     <= '0;
      sram_addr_l <= '0;
      Rdata       <= '0;
      Ready       <= 1'b0;
      Busy        <= 1'b0;
      SRAM_DOE    <= 1'b0;
      CE_N        <= 1'b1;
      OE_N        <= 1'b1;
      WE_N        <= 1'b1;
      UB_N        <= 1'b1;
      LB_N        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            write_l <= Write;
            wdata_l <= Wdata;
            Busy    <= 1'b1;
            if (Addr == IO_ADDR) begin
              state <= IO;
            end else begin
              // The I/O address is never latched here, so it cannot reach the SRAM pins.
              sram_addr_l <= Addr;
              cnt         <= CNT_LOAD;
              state       <= ACCESS;
              CE_N        <= 1'b0;
              UB_N        <= 1'b0;
              LB_N        <= 1'b0;
              OE_N        <= Write;
              WE_N        <= ~Write;
              SRAM_DOE    <= Write;
            end
          end
        end

        ACCESS: begin
          if (cnt == '0) begin
            if (!write_l) Rdata <= SRAM_DIN;
            state    <= DONE;
            Ready    <= 1'b1;
            OE_N     <= 1'b1;
            WE_N     <= 1'b1;
            // After a write, chip select and the data driver stay on one more cycle as hold margin.
            CE_N     <= ~write_l;
            UB_N     <= ~write_l;
            LB_N     <= ~write_l;
            SRAM_DOE <= write_l;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        IO: begin
          if (!write_l) Rdata <= sw_sync;
          state <= DONE;
          Ready <= 1'b1;
        end

        DONE: begin
          state    <= IDLE;
          Ready    <= 1'b0;
          Busy     <= 1'b0;
          SRAM_DOE <= 1'b0;
          CE_N     <= 1'b1;
          OE_N     <= 1'b1;
          WE_N     <= 1'b1;
          UB_N     <= 1'b1;
          LB_N     <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
